alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
Execution-side consumer of the 4-bit aluop code produced by the ALU control decoder. It accepts an operation plus operands through a valid/ready handshake and computes the result. Logical and arithmetic ops complete in one cycle; shifts iterate one bit per cycle. It presents a registered result and zero flag through a second valid/ready handshake to the writeback/branch logic. It sits between ID/EX operand fetch and writeback in the multi-cycle core.

Parameters:
WIDTH, 32, datapath width in bits
SHW, 5, shift-amount width; shifts beyond 2**SHW-1 are not expressible

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request
aluop  input  4  operation code (see Behaviour)
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt or sign-extended immediate); shift source
shamt  input  SHW  shift amount, used only by shift ops
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)

Behaviour:
- One clock domain; rst_n is asynchronous and active-low, and its release is synchronous to clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, shift counter=0.
- aluop encoding:
  - 0 AND: a&b
  - 1 OR: a|b
  - 2 ADD: a+b, modulo 2**WIDTH, no overflow trap
  - 3 SLL: b<<shamt
  - 4 SRL: b>>shamt, logical
  - 6 SUB: a-b, modulo 2**WIDTH
  - 7 SLT: signed a<b gives 1, else 0
  - 5 and 8..15 are undefined: result=0, zero=1, single-cycle timing.
- States:
  - IDLE: in_ready=1, out_valid=0. The request is accepted on a clk edge where in_valid&&in_ready.
    - On accept, a non-shift op, or a shift with shamt=0, writes result/zero and goes to DONE.
    - On accept, a shift with shamt>0 loads b into the shift register, loads shamt into the counter, and goes to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle the register shifts one bit (left for SLL, right with zero fill for SRL) and the counter decrements.
    - When the counter reaches 1 on an edge, that edge performs the final shift, writes result/zero, and goes to DONE.
  - DONE: out_valid=1, in_ready=0. result and zero are held stable until out_ready=1. The edge where out_valid&&out_ready goes to IDLE.
- Latency:
  - Non-shift ops: out_valid rises the cycle after acceptance.
  - Shift by n>0: out_valid rises n+1 cycles after acceptance.
- Throughput: at most one request in flight. No back-to-back accept in the cycle the result drains; the earliest next accept is the following cycle.
- Opcode and operands are captured at acceptance. Input changes afterwards have no effect.
- The shift direction is latched at acceptance.
- out_ready held high in DONE drains in exactly one cycle. out_ready low holds DONE indefinitely.
- out_ready asserted while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored, and the request is not queued.
- Reset asserted mid-SHIFT or in DONE: everything returns to reset values immediately (asynchronously) and the in-flight op is discarded.
- result is registered only; no combinational path from the inputs to result or zero.

Decomposition:
- Package alu_pkg holds:
  - aluop constants ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT
  - the state enum (IDLE, SHIFT, DONE)
  - WIDTH/SHW defaults
- The alucontrol decoder imports the same constants.
- One sub-module, alu_comb: purely combinational single-cycle ops (AND/OR/ADD/SUB/SLT/undefined). alu_exec owns the FSM, the shift iteration and the output registers.

Test Plan:
- Reset then ADD a=5, b=7 accepted at cycle 0 -> out_valid at cycle 1, result=12, zero=0; out_ready=1 -> in_ready=1 at cycle 2.
- SUB a=0x1234, b=0x1234 -> result=0, zero=1. SLT a=0xFFFFFFFF, b=1 -> result=1.
- SLL b=0x1, shamt=4 -> in_ready=0 for cycles 1-5, out_valid at cycle 5, result=0x10. SRL b=0x80000000, shamt=31 -> out_valid at cycle 32, result=1.
- SLL shamt=0, b=0xABCD -> out_valid at cycle 1, result=0xABCD. aluop=5 -> result=0, zero=1 at cycle 1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after an ADD; result stays stable and in_ready stays 0.
  - in_valid pulses during this window are dropped.
  - out_ready=1 -> IDLE the next cycle.
- Assert rst_n=0 mid-way through SLL shamt=20 -> out_valid=0, result=0, in_ready=1 immediately. After release, a new ADD completes normally with no stale shift output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluop encodings, execution FSM states and
// default datapath sizes. Also imported by the alucontrol decoder.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SHW   = 5;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between operand fetch, the ALU and writeback.
// master = requester/consumer side, slave = alu_exec.
interface alu_exec_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, aluop, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, aluop, a, b, shamt, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU operations. Shift and undefined opcodes yield zero;
// shifts are iterated by alu_exec instead.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       i_aluop,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    logic w_lt;

    assign w_lt = ($signed(i_a) < $signed(i_b));

    // Opcode select for the logical/arithmetic group
    always_comb begin
        o_result = '0;
        case (i_aluop)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: accepts one op, computes it (shifts iterate one
// bit per cycle), then holds a registered result/zero until drained.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);

    alu_state_t       r_state;
    alu_state_t       w_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_shreg;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_multi;
    logic [WIDTH-1:0] w_comb;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_shifted;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .i_aluop  (bus.aluop),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_result (w_comb)
    );

    assign w_accept   = bus.in_valid && (r_state == IDLE);
    assign w_is_shift = (bus.aluop == ALU_SLL) || (bus.aluop == ALU_SRL);
    assign w_multi    = w_is_shift && (bus.shamt != '0);
    // A zero-distance shift is just a pass-through of b.
    assign w_first    = w_is_shift ? bus.b : w_comb;
    assign w_shifted  = r_left ? (r_shreg << 1) : (r_shreg >> 1);

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = w_multi ? SHIFT : DONE;
            SHIFT:   if (r_cnt == SHW'(1)) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift iteration, result/zero registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_multi) begin
                            r_shreg <= bus.b;
                            r_cnt   <= bus.shamt;
                            r_left  <= (bus.aluop == ALU_SLL);
                        end else begin
                            r_result <= w_first;
                            r_zero   <= (w_first == '0);
                        end
                    end
                end
                SHIFT: begin
                    r_shreg <= w_shifted;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_shifted;
                        r_zero   <= (w_shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table plus handshake, backpressure
// and reset-during-shift sequences.
module tb_alu_exec;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int S = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_exec_if #(.WIDTH(W), .SHW(S)) bus ();

    alu_exec #(.WIDTH(W), .SHW(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [S-1:0] sh;
        logic [W-1:0] res;
        logic         z;
        int           lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE, corrupt inputs after acceptance, wait for the
    // result, check latency/result/zero, then drain it.
    task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [S-1:0] sh,
                         input logic [W-1:0] res, input logic z, input int lat);
        int cyc;
        logic busy_ok;
        chk({name, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.aluop = op; bus.a = a; bus.b = b; bus.shamt = sh;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.aluop = (op == ALU_SLL) ? ALU_SRL : (op == ALU_SRL) ? ALU_SLL : ALU_ADD;
        bus.a = ~a; bus.b = ~b; bus.shamt = ~sh;
        cyc = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, ".latency"}, 32'(cyc), 32'(lat));
        chk({name, ".busy"}, 32'(busy_ok && !bus.in_ready), 32'd1);
        chk({name, ".result"}, bus.result, res);
        chk({name, ".zero"}, 32'(bus.zero), 32'(z));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({name, ".drained"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        vecs[0]  = '{ALU_ADD, 32'd5,          32'd7,          5'd0,  32'd12,         1'b0, 1};
        vecs[1]  = '{ALU_SUB, 32'h1234,       32'h1234,       5'd0,  32'd0,          1'b1, 1};
        vecs[2]  = '{ALU_SLT, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1'b0, 1};
        vecs[3]  = '{ALU_SLT, 32'd1,          32'hFFFF_FFFF,  5'd0,  32'd0,          1'b1, 1};
        vecs[4]  = '{ALU_SLT, 32'd5,          32'd5,          5'd0,  32'd0,          1'b1, 1};
        vecs[5]  = '{ALU_AND, 32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_F000,  1'b0, 1};
        vecs[6]  = '{ALU_OR,  32'h0000_F0F0,  32'h0000_FF00,  5'd0,  32'h0000_FFF0,  1'b0, 1};
        vecs[7]  = '{ALU_ADD, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1'b1, 1};
        vecs[8]  = '{ALU_SUB, 32'd0,          32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0, 1};
        vecs[9]  = '{ALU_SLL, 32'd0,          32'd1,          5'd4,  32'h10,         1'b0, 5};
        vecs[10] = '{ALU_SRL, 32'd0,          32'h8000_0000,  5'd31, 32'd1,          1'b0, 32};
        vecs[11] = '{ALU_SLL, 32'd0,          32'hABCD,       5'd0,  32'hABCD,       1'b0, 1};
        vecs[12] = '{4'd5,    32'd9,          32'd3,          5'd2,  32'd0,          1'b1, 1};
        vecs[13] = '{4'd15,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'd0,          1'b1, 1};
        vecs[14] = '{ALU_SLL, 32'd0,          32'd1,          5'd31, 32'h8000_0000,  1'b0, 32};
        vecs[15] = '{ALU_SRL, 32'd0,          32'hFFFF_FFFF,  5'd4,  32'h0FFF_FFFF,  1'b0, 5};
        vecs[16] = '{ALU_SLL, 32'd0,          32'hC000_0001,  5'd2,  32'h0000_0004,  1'b0, 3};
        vecs[17] = '{ALU_SRL, 32'd0,          32'h0000_0001,  5'd1,  32'd0,          1'b1, 2};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.aluop = '0;
        bus.a = '0; bus.b = '0; bus.shamt = '0;

        // Reset values
        #12;
        chk("reset.flags", 32'({bus.in_ready, bus.out_valid, bus.zero}), 32'b100);
        chk("reset.result", bus.result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh,
                  vecs[i].res, vecs[i].z, vecs[i].lat);
        end

        // out_ready while idle is ignored
        bus.out_ready = 1'b1;
        tick(); tick();
        bus.out_ready = 1'b0;
        chk("idle_oready.flags", 32'({bus.in_ready, bus.out_valid}), 32'b10);

        // Backpressure: result held, in_valid pulses dropped
        begin
            logic stable;
            bus.aluop = ALU_ADD; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            chk("bp.valid", 32'(bus.out_valid), 32'd1);
            stable = 1'b1;
            for (int c = 0; c < 10; c++) begin
                bus.in_valid = c[0];
                bus.aluop = ALU_SUB; bus.a = 32'(c); bus.b = 32'd100;
                tick();
                if (bus.result !== 32'd7 || bus.zero !== 1'b0 || bus.in_ready !== 1'b0 ||
                    bus.out_valid !== 1'b1) stable = 1'b0;
            end
            chk("bp.stable", 32'(stable), 32'd1);
            // Drain with a new request already waiting: it must not be taken
            // on the drain edge, only on the next one.
            bus.aluop = ALU_ADD; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk("bp.drain", 32'({bus.out_valid, bus.in_ready}), 32'b01);
            tick();
            bus.in_valid = 1'b0;
            chk("next.valid", 32'(bus.out_valid), 32'd1);
            chk("next.result", bus.result, 32'd2);
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            tick();
            chk("no_queue", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end

        // Reset asserted during a long shift
        bus.aluop = ALU_SLL; bus.b = 32'd1; bus.shamt = 5'd20; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("mid_shift.busy", 32'({bus.in_ready, bus.out_valid}), 32'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.flags", 32'({bus.in_ready, bus.out_valid, bus.zero}), 32'b100);
        chk("async_rst.result", bus.result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op("post_rst_add", ALU_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1);
        for (int c = 0; c < 25; c++) tick();
        chk("no_stale", 32'({bus.out_valid, bus.in_ready}), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
